// File: rtl/seven_segment_display_capture.sv
// Seven-segment display capture: samples an active-low segment bus and a
// one-hot anode bus, waits for a pattern to hold for STABLE_CYCLES edges,
// and decodes it back to a hex nibble for the addressed digit.
// Optional feature macro: SEVEN_SEG_CAPTURE_BLANK_EN. When it is defined,
// the all-off pattern 7F is accepted as a blank digit instead of being
// reported as a bad pattern.
module seven_segment_display_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  anode_in,
  input  logic        clear,
  output logic [15:0] digits_out,
  output logic [3:0]  digit_valid,
  output logic        update,
  output logic        bad_pattern,
  output logic [7:0]  bad_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
`ifdef SEVEN_SEG_CAPTURE_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [10:0]       samp;
  logic [10:0]       cur;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              diff, cur_hot;
  logic              wr, dec_ok, blank, upd_c, bad_c;
  logic [3:0]        dec_nib;

  function automatic logic is_onehot(input logic [3:0] a);
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction

  // Returns {ok, nibble}; ok is low for any pattern outside the hex table.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h01: return 5'h10;
      7'h4F: return 5'h11;
      7'h12: return 5'h12;
      7'h06: return 5'h13;
      7'h4C: return 5'h14;
      7'h24: return 5'h15;
      7'h20: return 5'h16;
      7'h0F: return 5'h17;
      7'h00: return 5'h18;
      7'h04: return 5'h19;
      7'h08: return 5'h1A;
      7'h60: return 5'h1B;
      7'h31: return 5'h1C;
      7'h42: return 5'h1D;
      7'h30: return 5'h1E;
      7'h38: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  assign cur     = {anode_in, seg_in};
  assign diff    = (cur != samp);
  assign cur_hot = is_onehot(anode_in);

  // Stability count: restart at 1 on any change, otherwise count up and saturate.
  always_comb begin
    cnt_nxt = cnt;
    if (diff)                cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
  end

  // Sample register and stability counter; clear forgets the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= '0;
      cnt  <= '0;
    end else begin
      samp <= cur;
      cnt  <= clear ? '0 : cnt_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  // FSM next state. CAPTURE is entered on the edge where the count reaches
  // STABLE_CYCLES, so the write lands one edge later, on the capture edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cur_hot) state_nxt = SETTLE;
      SETTLE: begin
        if (diff && !cur_hot)     state_nxt = IDLE;
        else if (cnt_nxt == CNT_MAX) state_nxt = CAPTURE;
      end
      CAPTURE, HOLD: begin
        if (diff) state_nxt = cur_hot ? SETTLE : IDLE;
        else      state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: decode the held sample while in CAPTURE; clear suppresses it.
  always_comb begin
    wr      = (state == CAPTURE) && !clear;
    {dec_ok, dec_nib} = decode(samp[6:0]);
    blank   = BLANK_EN && (samp[6:0] == 7'h7F);
    upd_c   = wr && (dec_ok || blank);
    bad_c   = wr && !dec_ok && !blank;
  end

  // Captured digit state, pulses and saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_out  <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      bad_pattern <= 1'b0;
      bad_count   <= '0;
    end else if (clear) begin
      digits_out  <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      bad_pattern <= 1'b0;
      bad_count   <= '0;
    end else begin
      update      <= upd_c;
      bad_pattern <= bad_c;
      for (int i = 0; i < 4; i++) begin
        if (wr && samp[7+i]) begin
          if (dec_ok) begin
            digits_out[4*i +: 4] <= dec_nib;
            digit_valid[i]       <= 1'b1;
          end else begin
            if (blank) digits_out[4*i +: 4] <= 4'h0;
            digit_valid[i] <= 1'b0;
          end
        end
      end
      if (bad_c && bad_count != 8'hFF) bad_count <= bad_count + 8'd1;
    end
  end

endmodule
